i281_exec_unit: RTL and testbench

I281_EXEC_UNIT -- requirements
Module: i281_exec_unit

---
 rtl/i281_pkg.sv | 35 +++
 rtl/i281_alu_comb.sv | 47 ++++
 rtl/i281_exec_unit.sv | 169 ++++++++++++++++
 tb/tb_i281_exec_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/i281_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for the i281 execution unit.
package i281_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [3:0] make_flags(input logic c, input logic n,
                                              input logic o, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_O] = o;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/i281_alu_comb.sv
// Single-cycle ALU ops (ADD/SUB/AND/OR/XOR) with C/N/O/Z flags; iterative ops yield zero here.
module i281_alu_comb
    import i281_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            c;
    logic            o;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        result_o = '0;
        c        = 1'b0;
        o        = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                c        = sum[DATA_W];
                o        = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                // The extended top bit of a zero-extended difference is the borrow.
                result_o = diff[DATA_W-1:0];
                c        = diff[DATA_W];
                o        = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
        flags_o = make_flags(c, result_o[MSB], o, result_o == '0);
    end

endmodule

// File: rtl/i281_exec_unit.sv
// Execution unit: IDLE/BUSY/DONE handshake FSM, bit-serial SHL/SHR, shift-add MUL,
// and registered result/flags; single-cycle ops come from i281_alu_comb.
module i281_exec_unit
    import i281_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int              MSB     = DATA_W - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    tgt_q, tgt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [3:0]          flags_q, flags_d;

    logic [DATA_W-1:0]   alu_result;
    logic [3:0]          alu_flags;
    logic [CNT_W-1:0]    shamt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_iter;
    logic [DATA_W:0]     add_hi;
    logic [DATA_W-1:0]   mul_hi;
    logic [DATA_W-1:0]   mul_lo;
    logic [DATA_W-1:0]   shl_v;
    logic [DATA_W-1:0]   shr_v;

    i281_alu_comb #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op),
        .a_i      (in_a),
        .b_i      (in_b),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    always_comb begin
        shamt     = (32'(in_b) > 32'(DATA_W)) ? FULL_CNT : in_b[CNT_W-1:0];
        cnt_inc   = cnt_q + CNT_W'(1);
        last_iter = (cnt_inc == tgt_q);
        // Multiplier shifts right through b_q; product high half accumulates in acc_q.
        add_hi    = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_hi    = add_hi[DATA_W:1];
        mul_lo    = {add_hi[0], b_q[DATA_W-1:1]};
        shl_v     = {a_q[DATA_W-2:0], 1'b0};
        shr_v     = {1'b0, a_q[DATA_W-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    a_d   = in_a;
                    b_d   = in_b;
                    acc_d = '0;
                    cnt_d = '0;
                    if (op == OP_MUL) begin
                        tgt_d   = FULL_CNT;
                        state_d = ST_BUSY;
                    end else if (op == OP_SHL || op == OP_SHR) begin
                        if (shamt == '0) begin
                            result_d = in_a;
                            flags_d  = make_flags(1'b0, in_a[MSB], 1'b0, in_a == '0);
                            state_d  = ST_DONE;
                        end else begin
                            tgt_d   = shamt;
                            state_d = ST_BUSY;
                        end
                    end else begin
                        result_d = alu_result;
                        flags_d  = alu_flags;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_inc;
                case (op_q)
                    OP_SHL: begin
                        a_d = shl_v;
                        if (last_iter) begin
                            result_d = shl_v;
                            flags_d  = make_flags(a_q[MSB], shl_v[MSB], 1'b0, shl_v == '0);
                            state_d  = ST_DONE;
                        end
                    end
                    OP_SHR: begin
                        a_d = shr_v;
                        if (last_iter) begin
                            result_d = shr_v;
                            flags_d  = make_flags(a_q[0], shr_v[MSB], 1'b0, shr_v == '0);
                            state_d  = ST_DONE;
                        end
                    end
                    default: begin
                        acc_d = mul_hi;
                        b_d   = mul_lo;
                        if (last_iter) begin
                            result_d = mul_lo;
                            flags_d  = make_flags(mul_hi != '0, mul_lo[MSB], 1'b0, mul_lo == '0);
                            state_d  = ST_DONE;
                        end
                    end
                endcase
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            tgt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_i281_exec_unit.sv
// Directed bench for i281_exec_unit at DATA_W=8 with hand-computed results, flags and latencies.
module tb_i281_exec_unit;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;

    int total;
    int bad;

    i281_exec_unit #(.DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one request for one edge; lat = edges (counting the accepting edge) until out_valid.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        @(negedge clock);
        op = o; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags); end
    endtask

    task automatic test_add();
        int lat;
        run_op(3'b000, 8'h7F, 8'h01, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
        total++; if (result !== 8'h80) begin bad++; $display("FAIL add_result got=%h want=80", result); end
        total++; if (flags !== 4'b0110) begin bad++; $display("FAIL add_flags got=%b want=0110", flags); end
        retire();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_retire_valid got=%b want=0", out_valid); end
        total++; if (flags !== 4'b0110) begin bad++; $display("FAIL add_idle_flags got=%b want=0110", flags); end
    endtask

    task automatic test_sub();
        int lat;
        run_op(3'b001, 8'h05, 8'h05, lat);
        total++; if (result !== 8'h00 || flags !== 4'b0001 || lat !== 1) begin
            bad++; $display("FAIL sub_eq got=%h/%b/%0d want=00/0001/1", result, flags, lat); end
        retire();
        run_op(3'b001, 8'h00, 8'h01, lat);
        total++; if (result !== 8'hFF || flags !== 4'b1100) begin
            bad++; $display("FAIL sub_borrow got=%h/%b want=FF/1100", result, flags); end
        retire();
    endtask

    task automatic test_logic();
        int lat;
        run_op(3'b010, 8'hF0, 8'h3C, lat);
        total++; if (result !== 8'h30 || flags !== 4'b0000) begin
            bad++; $display("FAIL and got=%h/%b want=30/0000", result, flags); end
        retire();
        run_op(3'b011, 8'h00, 8'h00, lat);
        total++; if (result !== 8'h00 || flags !== 4'b0001) begin
            bad++; $display("FAIL or_zero got=%h/%b want=00/0001", result, flags); end
        retire();
        run_op(3'b100, 8'hFF, 8'h0F, lat);
        total++; if (result !== 8'hF0 || flags !== 4'b0100) begin
            bad++; $display("FAIL xor got=%h/%b want=F0/0100", result, flags); end
        retire();
    endtask

    task automatic test_mul();
        int lat;
        run_op(3'b111, 8'h10, 8'h11, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL mul_latency got=%0d want=9", lat); end
        total++; if (result !== 8'h10 || flags !== 4'b1000) begin
            bad++; $display("FAIL mul_hi got=%h/%b want=10/1000", result, flags); end
        retire();
        run_op(3'b111, 8'h0F, 8'h0F, lat);
        total++; if (result !== 8'hE1 || flags !== 4'b0100 || lat !== 9) begin
            bad++; $display("FAIL mul_lo got=%h/%b/%0d want=E1/0100/9", result, flags, lat); end
        retire();
    endtask

    task automatic test_shift();
        int lat;
        run_op(3'b110, 8'h81, 8'h01, lat);
        total++; if (result !== 8'h40 || flags !== 4'b1000 || lat !== 2) begin
            bad++; $display("FAIL shr1 got=%h/%b/%0d want=40/1000/2", result, flags, lat); end
        retire();
        run_op(3'b101, 8'h81, 8'h20, lat);
        total++; if (result !== 8'h00 || flags !== 4'b1001 || lat !== 9) begin
            bad++; $display("FAIL shl_sat got=%h/%b/%0d want=00/1001/9", result, flags, lat); end
        retire();
        run_op(3'b101, 8'h81, 8'h00, lat);
        total++; if (result !== 8'h81 || flags !== 4'b0100 || lat !== 1) begin
            bad++; $display("FAIL shl0 got=%h/%b/%0d want=81/0100/1", result, flags, lat); end
        retire();
        run_op(3'b110, 8'h81, 8'h08, lat);
        total++; if (result !== 8'h00 || flags !== 4'b1001 || lat !== 9) begin
            bad++; $display("FAIL shr8 got=%h/%b/%0d want=00/1001/9", result, flags, lat); end
        retire();
        run_op(3'b101, 8'h03, 8'h07, lat);
        total++; if (result !== 8'h80 || flags !== 4'b1100 || lat !== 8) begin
            bad++; $display("FAIL shl7 got=%h/%b/%0d want=80/1100/8", result, flags, lat); end
        retire();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(3'b000, 8'h01, 8'h02, lat);
        @(negedge clock);
        op = 3'b100; in_a = 8'hAA; in_b = 8'h55; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h03 || flags !== 4'b0000) begin
                bad++; $display("FAIL hold_%0d got=%b/%b/%h/%b want=1/0/03/0000", i, out_valid, in_ready, result, flags); end
        end
        @(negedge clock);
        op = 3'b011; in_a = 8'h0F; in_b = 8'hF0; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL retire_no_accept got=%b/%b want=0/1", out_valid, in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 8'hFF || flags !== 4'b0100) begin
            bad++; $display("FAIL next_accept got=%b/%h/%b want=1/FF/0100", out_valid, result, flags); end
        retire();
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        @(negedge clock);
        op = 3'b111; in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || flags !== 4'b0000 || result !== 8'h00) begin
            bad++; $display("FAIL abort got=%b/%b/%b/%h want=1/0/0000/00", in_ready, out_valid, flags, result); end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (out_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_result got=%0d want=0", seen); end
        run_op(3'b000, 8'h01, 8'h01, lat);
        total++; if (result !== 8'h02 || flags !== 4'b0000 || lat !== 1) begin
            bad++; $display("FAIL post_reset_add got=%h/%b/%0d want=02/0000/1", result, flags, lat); end
        retire();
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'b000; in_a = 8'h00; in_b = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock);
        reset = 1'b0;
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_shift();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
